md_seq_ctrl: RTL and testbench
==============================

Name: md_seq_ctrl

Overview:
- Sequences the shared multi-cycle multiply/divide unit on behalf of the execute (X) stage.
- Detects mul/div R-type instructions in X, latches operands and destination, and pulses the unit's start strobe.
- Holds F/D/X stalled until the unit reports ready or times out.
- Injects the result, or an $rstatus exception write, into the X/M latch for exactly one cycle.

Parameters:
- MAX_CYCLES, 40, maximum WAIT cycles before a timeout exception is declared.
- CNT_W, $clog2(MAX_CYCLES+1), width of the cycle counter (derived; do not override).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- insn_x  in  32  instruction in X stage (opcode [31:27], rd [26:22], ALUop [6:2]).
- valid_x  in  1  insn_x is a live, non-bubble instruction.
- flush  in  1  squash request from later stage; aborts any in-flight operation.
- op_a  in  32  bypassed rs value for insn_x.
- op_b  in  32  bypassed rt value for insn_x.
- md_ctrl_mult  out  1  one-cycle start strobe, multiply.
- md_ctrl_div  out  1  one-cycle start strobe, divide.
- md_op_a  out  32  latched operand A, held stable for the whole operation.
- md_op_b  out  32  latched operand B, held stable for the whole operation.
- md_result  in  32  unit result.
- md_exception  in  1  unit exception (overflow or divide-by-zero), valid with md_ready.
- md_ready  in  1  unit result valid.
- stall  out  1  freeze PC, F/D and D/X latches; X/M receives a bubble.
- busy  out  1  state != IDLE.
- wb_valid  out  1  one-cycle register-write request into X/M.
- wb_rd  out  5  destination register.
- wb_data  out  32  write data.

Behaviour:
- Reset (async, reset=0): state=IDLE; count=0; md_ctrl_*=0; md_op_a/md_op_b=0; wb_valid=0; wb_rd=0; wb_data=0.
- detect = valid_x & opcode==5'b00000 & ALUop in {5'b00110 (mul), 5'b00111 (div)}.
- States: IDLE, WAIT, DONE.
- IDLE:
  - stall = detect & ~flush (combinational, same cycle).
  - On detect & ~flush: latch op_a, op_b, rd, is_div; count<=0; register md_ctrl_mult/md_ctrl_div=1 for the next cycle only; go to WAIT.
- WAIT:
  - stall=1.
  - md_ready is ignored in the first WAIT cycle (the strobe cycle), which guards against stale ready.
  - Thereafter each cycle: if md_ready, capture md_result/md_exception and go to DONE.
  - Else if count==MAX_CYCLES-1, force the exception and go to DONE.
  - Else count<=count+1.
  - md_ready and the timeout in the same cycle: ready wins.
- DONE:
  - stall=0; wb_valid=1 for this single cycle; next state IDLE.
  - The mul/div leaves X at this edge.
  - Detection is suppressed in DONE, so the same instruction is never restarted.
- Writeback:
  - No exception: wb_rd=latched rd, wb_data=result.
  - Exception or timeout: wb_rd=5'd30, wb_data=32'd4 (mul) or 32'd5 (div).
  - No exception and rd==0: wb_valid=0 (no write), but DONE still releases the stall.
- Latency:
  - Detect at cycle T; strobe at T+1.
  - Earliest ready is accepted at T+2, giving DONE/wb_valid at T+3.
  - Stall cycles = T .. (accept cycle).
- flush:
  - In any state, at the next edge: state=IDLE, count=0, strobes=0, wb_valid=0. No writeback.
  - In IDLE, flush masks detect.
  - The unit is not told to abort; its late md_ready is ignored because ready is sampled only in WAIT.
- md_op_a/md_op_b change only on an IDLE->WAIT transition.

Decomposition:
- Shared package md_ctrl_pkg:
  - OPC_RTYPE=5'b00000, ALUOP_MUL=5'b00110, ALUOP_DIV=5'b00111.
  - RSTATUS_REG=5'd30, STATUS_MUL=32'd4, STATUS_DIV=32'd5.
  - State enum {IDLE, WAIT, DONE}.
- One sub-module, md_timeout_counter: clear, enable, terminal-count flag at MAX_CYCLES-1, async active-low reset.

Test Plan:
- mul rd=5, op_a=7, op_b=6; unit ready 3 cycles after strobe with 42 -> stall high from detect to accept; single wb_valid with wb_rd=5, wb_data=42; strobe md_ctrl_mult exactly one cycle.
- div rd=3, op_a=10, op_b=0; unit returns ready with md_exception=1 -> wb_rd=30, wb_data=5, no write to r3.
- mul with md_ready held high on the strobe cycle, result accepted the next cycle -> first-cycle ready ignored; DONE one cycle after acceptance.
- div, unit never ready, MAX_CYCLES=40 -> timeout after 40 WAIT cycles; wb_rd=30, wb_data=5; stall released in DONE.
- mul rd=0 -> no wb_valid; stall released; next instruction proceeds.
- flush asserted mid-WAIT, then reset=0 asserted asynchronously mid-WAIT in a second run -> IDLE next edge with no writeback for flush; immediate zeroed outputs for reset; a subsequent mul completes normally.

Source files
------------

// File: rtl/md_ctrl_pkg.sv
// Shared encodings and helpers for the multiply/divide sequencing controller.
package md_ctrl_pkg;

  localparam logic [4:0]  OPC_RTYPE   = 5'b00000;
  localparam logic [4:0]  ALUOP_MUL   = 5'b00110;
  localparam logic [4:0]  ALUOP_DIV   = 5'b00111;

  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] STATUS_MUL  = 32'd4;
  localparam logic [31:0] STATUS_DIV  = 32'd5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } md_state_e;

  // True when the instruction encodes an R-type mul or div.
  function automatic logic is_md_insn(input logic [4:0] opcode, input logic [4:0] aluop);
    return (opcode == OPC_RTYPE) && ((aluop == ALUOP_MUL) || (aluop == ALUOP_DIV));
  endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Cycle counter that bounds how long the sequencer waits on the mul/div unit.
module md_timeout_counter #(
  parameter  int unsigned MAX_CYCLES = 40,
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/md_seq_ctrl.sv
// Sequences the shared multi-cycle mul/div unit for the X stage: latches
// operands, strobes the unit, stalls the front end, and injects the result
// (or an $rstatus exception write) into X/M for one cycle.
module md_seq_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] insn_x,
  input  logic        valid_x,
  input  logic        flush,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_op_a,
  output logic [31:0] md_op_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  md_state_e   state_q, state_d;
  logic        mult_q, mult_d;
  logic        div_q, div_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_div_q, is_div_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        detect;
  logic        first_wait;
  logic        cnt_clear;
  logic        cnt_en;
  logic        cnt_tc;
  logic        stall_c;
  logic        unused_insn_bits;

  // Only opcode, rd and ALUop fields of the instruction matter here.
  assign unused_insn_bits = ^{insn_x[21:7], insn_x[1:0]};

  assign detect = valid_x & is_md_insn(insn_x[31:27], insn_x[6:2]);

  // The start strobe is high exactly in the first WAIT cycle, so it doubles
  // as the marker for the cycle in which a stale md_ready must be ignored.
  assign first_wait = mult_q | div_q;

  md_timeout_counter #(
    .MAX_CYCLES(MAX_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .tc     (cnt_tc)
  );

  // Next-state and registered-output logic; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    mult_d     = 1'b0;
    div_d      = 1'b0;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    rd_d       = rd_q;
    is_div_d   = is_div_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    stall_c    = 1'b0;
    cnt_clear  = 1'b1;
    cnt_en     = 1'b0;

    case (state_q)
      IDLE: begin
        stall_c = detect & ~flush;
        if (detect && !flush) begin
          state_d  = WAIT;
          op_a_d   = op_a;
          op_b_d   = op_b;
          rd_d     = insn_x[26:22];
          is_div_d = (insn_x[6:2] == ALUOP_DIV);
          mult_d   = (insn_x[6:2] != ALUOP_DIV);
          div_d    = (insn_x[6:2] == ALUOP_DIV);
        end
      end

      WAIT: begin
        stall_c = 1'b1;
        if (md_ready && !first_wait) begin
          state_d = DONE;
          if (md_exception) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = RSTATUS_REG;
            wb_data_d  = is_div_q ? STATUS_DIV : STATUS_MUL;
          end else begin
            wb_valid_d = (rd_q != 5'd0);
            wb_rd_d    = rd_q;
            wb_data_d  = md_result;
          end
        end else if (cnt_tc) begin
          state_d    = DONE;
          wb_valid_d = 1'b1;
          wb_rd_d    = RSTATUS_REG;
          wb_data_d  = is_div_q ? STATUS_DIV : STATUS_MUL;
        end else begin
          cnt_clear = 1'b0;
          cnt_en    = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d    = IDLE;
      mult_d     = 1'b0;
      div_d      = 1'b0;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      cnt_clear  = 1'b1;
      cnt_en     = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mult_q     <= 1'b0;
      div_q      <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rd_q       <= '0;
      is_div_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      mult_q     <= mult_d;
      div_q      <= div_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      rd_q       <= rd_d;
      is_div_q   <= is_div_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign md_ctrl_mult = mult_q;
  assign md_ctrl_div  = div_q;
  assign md_op_a      = op_a_q;
  assign md_op_b      = op_b_q;
  assign stall        = stall_c;
  assign busy         = (state_q != IDLE);
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Self-checking bench for md_seq_ctrl: directed scenarios plus randomized
// back-to-back operations checked against a timeline model.
module tb_md_seq_ctrl;

  localparam int MAXC = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] insn_x;
  logic        valid_x;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_op_a;
  logic [31:0] md_op_b;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  md_seq_ctrl #(.MAX_CYCLES(MAXC)) dut (
    .clock        (clock),
    .reset        (reset),
    .insn_x       (insn_x),
    .valid_x      (valid_x),
    .flush        (flush),
    .op_a         (op_a),
    .op_b         (op_b),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .md_op_a      (md_op_a),
    .md_op_b      (md_op_b),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_ready     (md_ready),
    .stall        (stall),
    .busy         (busy),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
  );

  function automatic logic [31:0] mk_insn(input bit is_div, input logic [4:0] rd);
    logic [31:0] r;
    r        = $urandom;
    r[31:27] = 5'b00000;
    r[26:22] = rd;
    r[6:2]   = is_div ? 5'b00111 : 5'b00110;
    return r;
  endfunction

  task automatic idle_inputs();
    valid_x      = 1'b0;
    flush        = 1'b0;
    md_ready     = 1'b0;
    md_exception = 1'b0;
    insn_x       = $urandom;
    op_a         = $urandom;
    op_b         = $urandom;
    md_result    = $urandom;
  endtask

  // One operation from detect cycle (c=0) through the DONE cycle.
  // rdy: cycle index of the unit's ready pulse (0 = never); early adds a
  // stale ready in the strobe cycle. Expected timeline: accepted at cycle
  // rdy when 2 <= rdy <= MAXC, else timeout with the exception forced at MAXC.
  // Stall covers cycles 0..k, writeback appears at k+1.
  task automatic run_op(input bit is_div, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        input int rdy, input bit early,
                        input logic [31:0] res, input bit exc);
    int          k;
    bit          tmo;
    bit          exp_wv;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic [31:0] insn;
    tmo = !(rdy >= 2 && rdy <= MAXC);
    k   = tmo ? MAXC : rdy;
    if (tmo || exc) begin
      exp_wv   = 1'b1;
      exp_rd   = 5'd30;
      exp_data = is_div ? 32'd5 : 32'd4;
    end else begin
      exp_wv   = (rd != 5'd0);
      exp_rd   = rd;
      exp_data = res;
    end
    insn = mk_insn(is_div, rd);
    for (int c = 0; c <= k + 1; c++) begin
      insn_x  = insn;
      valid_x = 1'b1;
      flush   = 1'b0;
      op_a    = (c == 0) ? a : $urandom;
      op_b    = (c == 0) ? b : $urandom;
      if (rdy != 0 && c == rdy) begin
        md_ready     = 1'b1;
        md_result    = res;
        md_exception = exc;
      end else if (early && c == 1) begin
        md_ready     = 1'b1;
        md_result    = $urandom;
        md_exception = 1'($urandom_range(0, 1));
      end else begin
        md_ready     = 1'b0;
        md_result    = $urandom;
        md_exception = 1'b0;
      end
      @(negedge clock);
      total++;
      if (stall !== (c <= k)) begin
        bad++;
        $display("FAIL op_stall cyc=%0d got=%b exp=%b", c, stall, (c <= k));
      end
      total++;
      if (busy !== (c >= 1)) begin
        bad++;
        $display("FAIL op_busy cyc=%0d got=%b exp=%b", c, busy, (c >= 1));
      end
      total++;
      if (md_ctrl_mult !== (c == 1 && !is_div)) begin
        bad++;
        $display("FAIL op_strobe_mult cyc=%0d got=%b exp=%b", c, md_ctrl_mult, (c == 1 && !is_div));
      end
      total++;
      if (md_ctrl_div !== (c == 1 && is_div)) begin
        bad++;
        $display("FAIL op_strobe_div cyc=%0d got=%b exp=%b", c, md_ctrl_div, (c == 1 && is_div));
      end
      if (c >= 1) begin
        total++;
        if (md_op_a !== a || md_op_b !== b) begin
          bad++;
          $display("FAIL op_operands cyc=%0d got=%h/%h exp=%h/%h", c, md_op_a, md_op_b, a, b);
        end
      end
      total++;
      if (wb_valid !== (exp_wv && c == k + 1)) begin
        bad++;
        $display("FAIL op_wb_valid cyc=%0d got=%b exp=%b", c, wb_valid, (exp_wv && c == k + 1));
      end
      if (exp_wv && c == k + 1) begin
        total++;
        if (wb_rd !== exp_rd || wb_data !== exp_data) begin
          bad++;
          $display("FAIL op_wb_payload got=%0d/%h exp=%0d/%h", wb_rd, wb_data, exp_rd, exp_data);
        end
      end
      @(posedge clock);
      #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #3;
    total++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b%b exp=00", busy, stall);
    end
    total++;
    if (md_ctrl_mult !== 1'b0 || md_ctrl_div !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobe got=%b%b exp=00", md_ctrl_mult, md_ctrl_div);
    end
    total++;
    if (md_op_a !== 32'd0 || md_op_b !== 32'd0) begin
      bad++;
      $display("FAIL reset_operands got=%h/%h exp=0/0", md_op_a, md_op_b);
    end
    total++;
    if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_wb got=%b/%0d/%h exp=0/0/0", wb_valid, wb_rd, wb_data);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_mul_basic();
    run_op(1'b0, 5'd5, 32'd7, 32'd6, 4, 1'b0, 32'd42, 1'b0);
  endtask

  task automatic test_div_exception();
    run_op(1'b1, 5'd3, 32'd10, 32'd0, 3, 1'b0, 32'hdead_beef, 1'b1);
  endtask

  task automatic test_stale_ready();
    run_op(1'b0, 5'd12, 32'd3, 32'd9, 2, 1'b1, 32'd27, 1'b0);
  endtask

  task automatic test_timeout();
    run_op(1'b1, 5'd8, 32'd100, 32'd7, 0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_ready_at_limit();
    run_op(1'b0, 5'd17, 32'd11, 32'd13, MAXC, 1'b0, 32'd143, 1'b0);
  endtask

  task automatic test_rd_zero();
    run_op(1'b0, 5'd0, 32'd4, 32'd5, 3, 1'b0, 32'd20, 1'b0);
    run_op(1'b1, 5'd9, 32'd20, 32'd4, 5, 1'b0, 32'd5, 1'b0);
  endtask

  // Non-mul/div or squashed instructions must never start the unit.
  task automatic test_no_detect();
    logic [31:0] insn;
    int          kind;
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      kind = i % 4;
      insn = mk_insn(1'($urandom_range(0, 1)), 5'($urandom));
      case (kind)
        0: valid_x = 1'b0;
        1: begin
          valid_x = 1'b1;
          insn[6:2] = 5'($urandom_range(0, 5));
        end
        2: begin
          valid_x = 1'b1;
          insn[31:27] = 5'($urandom_range(1, 31));
        end
        default: begin
          valid_x = 1'b1;
          flush   = 1'b1;
        end
      endcase
      insn_x = insn;
      @(negedge clock);
      total++;
      if (stall !== 1'b0) begin
        bad++;
        $display("FAIL nodet_stall kind=%0d got=%b exp=0", kind, stall);
      end
      @(posedge clock);
      #1;
      idle_inputs();
      @(negedge clock);
      total++;
      if (busy !== 1'b0 || md_ctrl_mult !== 1'b0 || md_ctrl_div !== 1'b0) begin
        bad++;
        $display("FAIL nodet_start kind=%0d got=%b%b%b exp=000", kind, busy, md_ctrl_mult, md_ctrl_div);
      end
      @(posedge clock);
      #1;
    end
  endtask

  // Flush mid-WAIT: IDLE at the next edge, no writeback, late ready ignored.
  task automatic test_flush();
    int          f;
    logic [31:0] insn;
    f    = $urandom_range(1, 10);
    insn = mk_insn(1'b0, 5'd21);
    for (int c = 0; c <= f; c++) begin
      insn_x  = insn;
      valid_x = 1'b1;
      flush   = (c == f);
      op_a    = 32'd2;
      op_b    = 32'd3;
      @(negedge clock);
      total++;
      if (stall !== 1'b1) begin
        bad++;
        $display("FAIL flush_stall cyc=%0d got=%b exp=1", c, stall);
      end
      @(posedge clock);
      #1;
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      md_ready  = 1'b1;
      md_result = 32'd6;
      @(negedge clock);
      total++;
      if (busy !== 1'b0 || stall !== 1'b0) begin
        bad++;
        $display("FAIL flush_idle cyc=%0d got=%b%b exp=00", c, busy, stall);
      end
      total++;
      if (wb_valid !== 1'b0 || md_ctrl_mult !== 1'b0) begin
        bad++;
        $display("FAIL flush_nowb cyc=%0d got=%b%b exp=00", c, wb_valid, md_ctrl_mult);
      end
      @(posedge clock);
      #1;
    end
    idle_inputs();
    run_op(1'b0, 5'd21, 32'd2, 32'd3, 3, 1'b0, 32'd6, 1'b0);
  endtask

  // Asynchronous reset mid-WAIT zeroes outputs without waiting for an edge.
  task automatic test_async_reset();
    logic [31:0] insn;
    insn = mk_insn(1'b1, 5'd14);
    for (int c = 0; c < 6; c++) begin
      insn_x  = insn;
      valid_x = 1'b1;
      op_a    = 32'h1234_5678;
      op_b    = 32'h0000_0011;
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    #2;
    valid_x = 1'b0;
    reset   = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL areset_ctrl got=%b%b exp=00", busy, stall);
    end
    total++;
    if (md_op_a !== 32'd0 || md_op_b !== 32'd0) begin
      bad++;
      $display("FAIL areset_operands got=%h/%h exp=0/0", md_op_a, md_op_b);
    end
    total++;
    if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      bad++;
      $display("FAIL areset_wb got=%b/%0d/%h exp=0/0/0", wb_valid, wb_rd, wb_data);
    end
    idle_inputs();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    run_op(1'b0, 5'd7, 32'd9, 32'd9, 3, 1'b0, 32'd81, 1'b0);
  endtask

  // Randomized back-to-back operations.
  task automatic test_back_to_back();
    int rdy;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0:       rdy = 0;
        1:       rdy = $urandom_range(MAXC - 2, MAXC + 3);
        default: rdy = $urandom_range(2, 8);
      endcase
      run_op(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom,
             rdy, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0));
    end
    @(negedge clock);
    total++;
    if (busy !== 1'b0 || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_final got=%b%b exp=00", busy, wb_valid);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_div_exception();
    test_stale_ready();
    test_timeout();
    test_ready_at_limit();
    test_rd_zero();
    test_no_detect();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
